cnn_frame_buffer: RTL

Parametrised, double-buffered (ping-pong) image frame store that replaces the fixed 8×8 row-register bank between the SPI slave and the CNN core. It assembles a byte stream from the SPI slave into frames of ROWS rows × ROW_BITS bits. It holds up to two complete frames and streams a frame to the CNN core one row per cycle over a valid/ready handshake. While one frame is being read, the next frame can be written.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/cnn_frame_bank.sv | 37 +++
 rtl/cnn_frame_buffer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and geometry helpers for the CNN ping-pong frame buffer.
package cnn_pkg;

  typedef enum logic {StIdle, StStream} rdState_e;

  function automatic int unsigned bytesPerRow(int unsigned rowBits, int unsigned busBits);
    return rowBits / busBits;
  endfunction

  function automatic int unsigned frameBytes(int unsigned rows, int unsigned rowBits,
                                             int unsigned busBits);
    return rows * bytesPerRow(rowBits, busBits);
  endfunction

endpackage

// File: rtl/cnn_frame_bank.sv
// One frame bank: ROWS x ROW_BITS storage with byte-lane writes and a combinational row read.
module cnn_frame_bank
  import cnn_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned ROWS          = 8,
  parameter int unsigned ROW_BITS      = 8,
  localparam int unsigned BYTES_PER_ROW = bytesPerRow(ROW_BITS, DATAWIDTH_BUS),
  localparam int unsigned ROW_IDX_W     = $clog2(ROWS),
  localparam int unsigned LANE_W        = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [ROW_IDX_W-1:0]     wrRow,
  input  logic [LANE_W-1:0]        wrLane,
  input  logic [DATAWIDTH_BUS-1:0] wrData,
  input  logic [ROW_IDX_W-1:0]     rdRow,
  output logic [ROW_BITS-1:0]      rdData
);

  logic [ROW_BITS-1:0] mem [ROWS];

  // Lane 0 is the first byte of a row and occupies the most significant bits.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int l = 0; l < int'(BYTES_PER_ROW); l++) begin
        if (wrLane == LANE_W'(l)) begin
          mem[wrRow][(int'(BYTES_PER_ROW) - 1 - l) * int'(DATAWIDTH_BUS) +: DATAWIDTH_BUS]
            <= wrData;
        end
      end
    end
  end

  assign rdData = mem[rdRow];

endmodule

// File: rtl/cnn_frame_buffer.sv
// Ping-pong frame store: assembles SPI bytes into frames and streams rows to the CNN core.
module cnn_frame_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned ROWS          = 8,
  parameter int unsigned ROW_BITS      = 8,
  localparam int unsigned BYTES_PER_ROW = bytesPerRow(ROW_BITS, DATAWIDTH_BUS),
  localparam int unsigned ROW_IDX_W     = $clog2(ROWS),
  localparam int unsigned LANE_W        = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1
) (
  input  logic                     cnn_frame_buffer_CLOCK_50,
  input  logic                     cnn_frame_buffer_RESET_InLow,
  input  logic                     cnn_frame_buffer_WrSof_In,
  input  logic                     cnn_frame_buffer_WrValid_In,
  input  logic [DATAWIDTH_BUS-1:0] cnn_frame_buffer_WrData_InBUS,
  output logic                     cnn_frame_buffer_WrReady_Out,
  output logic                     cnn_frame_buffer_Drop_Out,
  output logic                     cnn_frame_buffer_FrameReady_Out,
  input  logic                     cnn_frame_buffer_RdStart_In,
  output logic                     cnn_frame_buffer_RowValid_Out,
  input  logic                     cnn_frame_buffer_RowReady_In,
  output logic [ROW_BITS-1:0]      cnn_frame_buffer_RowData_OutBUS,
  output logic [ROW_IDX_W-1:0]     cnn_frame_buffer_RowIndex_OutBUS,
  output logic                     cnn_frame_buffer_RowLast_Out
);

  localparam logic [ROW_IDX_W-1:0] LastRow  = ROW_IDX_W'(ROWS - 1);
  localparam logic [LANE_W-1:0]    LastLane = LANE_W'(BYTES_PER_ROW - 1);

  logic                 clk, rstN;
  logic [1:0]           fullCntQ, fullCntD;
  logic                 wbQ, wbD, rbQ, rbD;
  logic [ROW_IDX_W-1:0] wRowQ, wRowD, rowSel;
  logic [LANE_W-1:0]    wLaneQ, wLaneD, laneSel;
  logic                 dropQ, wrAccept, frameDone, rdDone;
  rdState_e             stateQ, stateD;
  logic [ROW_IDX_W-1:0] rowIdxQ, rowIdxD;
  logic                 rowLastQ, rowLastD;
  logic [ROW_BITS-1:0]  rdData0, rdData1;

  assign clk  = cnn_frame_buffer_CLOCK_50;
  assign rstN = cnn_frame_buffer_RESET_InLow;

  // Write side: SOF forces the byte position to zero, abandoning any partial frame.
  always_comb begin
    wrAccept  = cnn_frame_buffer_WrValid_In && (fullCntQ != 2'd2);
    rowSel    = cnn_frame_buffer_WrSof_In ? '0 : wRowQ;
    laneSel   = cnn_frame_buffer_WrSof_In ? '0 : wLaneQ;
    frameDone = wrAccept && (rowSel == LastRow) && (laneSel == LastLane);
    wRowD     = wRowQ;
    wLaneD    = wLaneQ;
    wbD       = wbQ;
    if (wrAccept) begin
      if (frameDone) begin
        wRowD  = '0;
        wLaneD = '0;
        wbD    = ~wbQ;
      end else if (laneSel == LastLane) begin
        wRowD  = rowSel + 1'b1;
        wLaneD = '0;
      end else begin
        wRowD  = rowSel;
        wLaneD = laneSel + 1'b1;
      end
    end else if (cnn_frame_buffer_WrSof_In) begin
      wRowD  = '0;
      wLaneD = '0;
    end
  end

  // Read FSM.
  always_comb begin
    stateD   = stateQ;
    rowIdxD  = rowIdxQ;
    rowLastD = rowLastQ;
    rbD      = rbQ;
    rdDone   = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (cnn_frame_buffer_RdStart_In && (fullCntQ != 2'd0)) begin
          stateD   = StStream;
          rowIdxD  = '0;
          rowLastD = 1'b0;
        end
      end
      StStream: begin
        if (cnn_frame_buffer_RowReady_In) begin
          if (rowLastQ) begin
            rdDone   = 1'b1;
            stateD   = StIdle;
            rowIdxD  = '0;
            rowLastD = 1'b0;
            rbD      = ~rbQ;
          end else begin
            rowIdxD  = rowIdxQ + 1'b1;
            rowLastD = (rowIdxQ + 1'b1) == LastRow;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Simultaneous completion and release leaves the count unchanged.
  always_comb begin
    fullCntD = fullCntQ;
    if (frameDone && !rdDone)      fullCntD = fullCntQ + 2'd1;
    else if (!frameDone && rdDone) fullCntD = fullCntQ - 2'd1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fullCntQ <= 2'd0;
      wbQ      <= 1'b0;
      rbQ      <= 1'b0;
      wRowQ    <= '0;
      wLaneQ   <= '0;
      dropQ    <= 1'b0;
      stateQ   <= StIdle;
      rowIdxQ  <= '0;
      rowLastQ <= 1'b0;
    end else begin
      fullCntQ <= fullCntD;
      wbQ      <= wbD;
      rbQ      <= rbD;
      wRowQ    <= wRowD;
      wLaneQ   <= wLaneD;
      dropQ    <= cnn_frame_buffer_WrValid_In && (fullCntQ == 2'd2);
      stateQ   <= stateD;
      rowIdxQ  <= rowIdxD;
      rowLastQ <= rowLastD;
    end
  end

  cnn_frame_bank #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS),
    .ROWS         (ROWS),
    .ROW_BITS     (ROW_BITS)
  ) bank0 (
    .clk   (clk),
    .wrEn  (wrAccept && !wbQ),
    .wrRow (rowSel),
    .wrLane(laneSel),
    .wrData(cnn_frame_buffer_WrData_InBUS),
    .rdRow (rowIdxQ),
    .rdData(rdData0)
  );

  cnn_frame_bank #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS),
    .ROWS         (ROWS),
    .ROW_BITS     (ROW_BITS)
  ) bank1 (
    .clk   (clk),
    .wrEn  (wrAccept && wbQ),
    .wrRow (rowSel),
    .wrLane(laneSel),
    .wrData(cnn_frame_buffer_WrData_InBUS),
    .rdRow (rowIdxQ),
    .rdData(rdData1)
  );

  assign cnn_frame_buffer_WrReady_Out     = (fullCntQ != 2'd2);
  assign cnn_frame_buffer_FrameReady_Out  = (fullCntQ != 2'd0);
  assign cnn_frame_buffer_Drop_Out        = dropQ;
  assign cnn_frame_buffer_RowValid_Out    = (stateQ == StStream);
  assign cnn_frame_buffer_RowIndex_OutBUS = rowIdxQ;
  assign cnn_frame_buffer_RowLast_Out     = rowLastQ;
  assign cnn_frame_buffer_RowData_OutBUS  =
    (stateQ == StStream) ? (rbQ ? rdData1 : rdData0) : '0;

endmodule
